// File: rtl/crg_pkg.sv
// Shared types and sizing for the coefficient byte encoder.
// Word count and counter widths derive from the polynomial geometry.
package crg_pkg;

    localparam int N_COEF = 256;
    localparam int COEF_W = 12;
    localparam int WORD_W = 64;
    localparam int Q      = 3329;

    localparam int N_WORDS = (N_COEF * COEF_W) / WORD_W;
    localparam int BUF_W   = WORD_W + COEF_W - 1;
    localparam int FILL_W  = $clog2(BUF_W + 1);
    localparam int CCNT_W  = $clog2(N_COEF + 1);
    localparam int WCNT_W  = $clog2(N_WORDS + 1);

    typedef logic [COEF_W-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        DONE
    } enc_state_t;

endpackage

// File: rtl/coef_cond_sub.sv
// Conditional subtract by Q; only built when CRG_COEF_REDUCE_EN is defined.
// Maps 0..4095 into 0..Q-1 for inputs below 2Q.
`ifdef CRG_COEF_REDUCE_EN
module coef_cond_sub
    import crg_pkg::*;
(
    input  coef_t coef_i,
    output coef_t coef_o
);

    localparam coef_t QC = coef_t'(Q);

    logic ge_q;

    assign ge_q   = (coef_i >= QC);
    assign coef_o = ge_q ? (coef_i - QC) : coef_i;

endmodule
`endif

// File: rtl/poly_byte_encoder.sv
// Packs 256 12-bit coefficients little-endian into 48 64-bit words.
// Define CRG_COEF_REDUCE_EN to reduce each coefficient mod Q on accept.
module poly_byte_encoder
    import crg_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              run_i,
    input  logic              coef_valid_i,
    input  logic [COEF_W-1:0] coef_i,
    output logic              coef_ready_o,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o,
    input  logic              word_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    if ((N_COEF * COEF_W) % WORD_W != 0) begin : g_geom_chk
        $error("N_COEF*COEF_W must be a multiple of WORD_W");
    end

    enc_state_t        state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CCNT_W-1:0] coef_cnt_q, coef_cnt_d;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;

    coef_t coef_in;
    logic  in_pack;
    logic  coef_hs;
    logic  word_hs;
    logic  last_word;

`ifdef CRG_COEF_REDUCE_EN
    coef_cond_sub u_cond_sub (
        .coef_i (coef_i),
        .coef_o (coef_in)
    );
`else
    assign coef_in = coef_i;
`endif

    assign in_pack = (state_q == PACK);

    // Both ready/valid are derived only from registered state.
    assign coef_ready_o = in_pack
                        & (fill_q < FILL_W'(WORD_W))
                        & (coef_cnt_q < CCNT_W'(N_COEF));
    assign word_valid_o = in_pack
                        & (fill_q >= FILL_W'(WORD_W));

    assign word_o = buf_q[WORD_W-1:0];
    assign busy_o = in_pack;
    assign done_o = (state_q == DONE);

    assign coef_hs   = coef_ready_o & coef_valid_i;
    assign word_hs   = word_valid_o & word_ready_i;
    assign last_word = (word_cnt_q == WCNT_W'(N_WORDS - 1));

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        fill_d     = fill_q;
        coef_cnt_d = coef_cnt_q;
        word_cnt_d = word_cnt_q;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (run_i) begin
                    state_d    = PACK;
                    buf_d      = '0;
                    fill_d     = '0;
                    coef_cnt_d = '0;
                    word_cnt_d = '0;
                end
            end
            (state_q == PACK): begin
                // Bits above fill are always zero, so OR-in is safe.
                if (coef_hs) begin
                    buf_d = buf_q
                          | (BUF_W'(coef_in) << fill_q);
                    fill_d     = fill_q + FILL_W'(COEF_W);
                    coef_cnt_d = coef_cnt_q + 1'b1;
                end else if (word_hs) begin
                    buf_d      = buf_q >> WORD_W;
                    fill_d     = fill_q - FILL_W'(WORD_W);
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (last_word) begin
                        state_d = DONE;
                    end
                end
            end
            (state_q == DONE): begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            fill_q     <= '0;
            coef_cnt_q <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            coef_cnt_q <= coef_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

endmodule

// File: tb/tb_poly_byte_encoder.sv
// Directed bench for poly_byte_encoder with a word scoreboard.
// Follows CRG_COEF_REDUCE_EN for the expected reduction behaviour.
module tb_poly_byte_encoder;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        run_i;
    logic        coef_valid_i;
    logic [11:0] coef_i;
    logic        coef_ready_o;
    logic        word_valid_o;
    logic [63:0] word_o;
    logic        word_ready_i;
    logic        busy_o;
    logic        done_o;

    int total = 0;
    int bad   = 0;

    logic [11:0] coefs [256];
    logic [63:0] first_w;

    always #5 clk_i = ~clk_i;

    poly_byte_encoder dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .run_i        (run_i),
        .coef_valid_i (coef_valid_i),
        .coef_i       (coef_i),
        .coef_ready_o (coef_ready_o),
        .word_valid_o (word_valid_o),
        .word_o       (word_o),
        .word_ready_i (word_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] red(input logic [11:0] c);
`ifdef CRG_COEF_REDUCE_EN
        if (int'(c) >= 3329) return 12'(int'(c) - 3329);
        return c;
`else
        return c;
`endif
    endfunction

    function automatic logic [63:0] exp_word(input int j);
        logic [63:0] w;
        logic [11:0] c;
        for (int b = 0; b < 64; b++) begin
            int s = 64 * j + b;
            c = red(coefs[s / 12]);
            w[b] = c[s % 12];
        end
        return w;
    endfunction

    // mode bit0: random backpressure/gaps, bit1: illegal run pulses
    task automatic run_poly(input int mode, input int abort_at,
                            output logic [63:0] first);
        logic [63:0] exq [$];
        logic [63:0] e;
        logic [63:0] w_prev;
        logic stall_prev;
        int idx, pushed, got, dones, post, cyc, fill_m;
        bit bp, ill, finished;
        bp = mode[0];
        ill = mode[1];
        idx = 0; pushed = 0; got = 0; dones = 0;
        post = 0; cyc = 0; stall_prev = 0;
        w_prev = '0; first = '0; finished = 0;
        @(negedge clk_i);
        run_i = 1'b1;
        coef_valid_i = 1'b0;
        word_ready_i = 1'b0;
        @(negedge clk_i);
        run_i = 1'b0;
        chk("busy_start", busy_o, 1);
        while (cyc < 4000) begin
            fill_m = idx * 12 - got * 64;
            chk("wvalid", word_valid_o, fill_m >= 64 && got < 48);
            chk("cready", coef_ready_o, fill_m < 64 && idx < 256);
            if (stall_prev) chk("stable", word_o, w_prev);
            if (done_o) begin
                dones++;
                chk("done_at48", got, 48);
            end
            if (dones > 0 && !done_o) chk("busy_after", busy_o, 0);
            if (dones > 0) post++;
            if (post == 3) begin
                finished = 1;
                break;
            end
            coef_valid_i = (idx < 256)
                         && (!bp || $urandom_range(0, 9) < 7);
            coef_i = coefs[(idx < 256) ? idx : 255];
            word_ready_i = !bp || ($urandom_range(0, 9) < 3);
            run_i = ill && dones == 0 && $urandom_range(0, 7) == 0;
            if (coef_valid_i && coef_ready_o) begin
                idx++;
                while (pushed < 48 && (pushed + 1) * 64 <= idx * 12) begin
                    exq.push_back(exp_word(pushed));
                    pushed++;
                end
            end
            if (word_valid_o && word_ready_i) begin
                if (exq.size() == 0) begin
                    chk("sb_empty", word_o, 64'hx);
                end else begin
                    e = exq.pop_front();
                    chk("word", word_o, e);
                end
                if (got == 0) first = word_o;
                got++;
            end
            stall_prev = word_valid_o && !word_ready_i;
            w_prev = word_o;
            if (abort_at > 0 && got == abort_at) begin
                finished = 1;
                break;
            end
            @(negedge clk_i);
            cyc++;
        end
        if (!finished) chk("timeout", cyc, 0);
        if (abort_at == 0) begin
            chk("ndone", dones, 1);
            chk("nwords", got, 48);
            chk("sb_left", exq.size(), 0);
        end else begin
            chk("abort_nodone", dones, 0);
        end
        @(negedge clk_i);
        run_i = 1'b0;
        coef_valid_i = 1'b0;
        word_ready_i = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wv"}, word_valid_o, 0);
        chk({tag, "_cr"}, coef_ready_o, 0);
        chk({tag, "_wo"}, word_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
    endtask

    initial begin
        rst_n_i = 1'b0;
        run_i = 1'b0;
        coef_valid_i = 1'b0;
        coef_i = '0;
        word_ready_i = 1'b0;
        #12;
        chk_zero("reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // coefficients while idle must not be absorbed
        coef_valid_i = 1'b1;
        coef_i = 12'hABC;
        word_ready_i = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            chk_zero("idle_ill");
        end
        coef_valid_i = 1'b0;

        for (int k = 0; k < 256; k++) coefs[k] = 12'(k);
        run_poly(0, 0, first_w);
        chk("ramp_w0", first_w, 64'h5004003002001000);

        for (int k = 0; k < 256; k++) coefs[k] = 12'hFFF;
        run_poly(0, 0, first_w);
`ifdef CRG_COEF_REDUCE_EN
        chk("ones_w0", first_w, 64'hE2FE2FE2FE2FE2FE);
`else
        chk("ones_w0", first_w, 64'hFFFFFFFFFFFFFFFF);
`endif

        for (int k = 0; k < 256; k++) coefs[k] = 12'h000;
        coefs[0] = 12'd3329;
        coefs[1] = 12'd3328;
        run_poly(0, 0, first_w);
`ifdef CRG_COEF_REDUCE_EN
        chk("redb_w0", first_w, 64'h0000000000D00000);
`else
        chk("redb_w0", first_w, 64'h0000000000D00D01);
`endif

        for (int k = 0; k < 256; k++) coefs[k] = 12'(k);
        run_poly(3, 0, first_w);
        chk("bp_w0", first_w, 64'h5004003002001000);

        run_poly(1, 10, first_w);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (2) begin
            @(negedge clk_i);
            chk_zero("midrst_hold");
        end
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk_zero("post_rst");
        run_poly(0, 0, first_w);
        chk("rerun_w0", first_w, 64'h5004003002001000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
